// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU types: load-type encodings and datapath width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_op_e;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
    return {{(DATA_W-16){h[15]}}, h};
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module   : load_align
// Brief    : Combinational lane select / extension of a load word and
//            misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import cpu_pkg::*;
(
  input  logic              is_load,
  input  logic [2:0]        load_op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Reserved encodings fall into the default arm and act as a word load.
  always_comb begin
    load_data  = rdata;
    misaligned = 1'b0;
    case (load_op)
      LOAD_LB:  load_data = sext8(w_byte);
      LOAD_LBU: load_data = {{(DATA_W-8){1'b0}}, w_byte};
      LOAD_LH: begin
        load_data  = sext16(w_half);
        misaligned = addr_lo[0];
      end
      LOAD_LHU: begin
        load_data  = {{(DATA_W-16){1'b0}}, w_half};
        misaligned = addr_lo[0];
      end
      default: begin
        load_data  = rdata;
        misaligned = (addr_lo != 2'd0);
      end
    endcase
    if (!is_load) begin
      misaligned = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MEM/WB pipeline register with load extraction, register-file
//            write qualification and retired-instruction counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [4:0]          mem_wreg,
  input  logic                mem_regwrite,
  input  logic                mem_link,
  input  logic                mem_is_load,
  input  logic [2:0]          mem_load_op,
  input  logic [1:0]          mem_addr_lo,
  input  logic [DATA_W-1:0]   mem_alu_result,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [DATA_W-1:0]   mem_pc,
  input  logic                stall,
  input  logic                flush,
  output logic                wb_valid,
  output logic [4:0]          wb_wreg,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic                wb_regwrite,
  output logic                wb_store_pc,
  output logic [DATA_W-1:0]   wb_inst_address,
  output logic                wb_addr_err,
  output logic [RETIRE_W-1:0] retire_count
);

  logic [DATA_W-1:0]   w_load_data;
  logic                w_misaligned;
  logic [DATA_W-1:0]   w_next_wdata;

  logic                r_valid;
  logic [4:0]          r_wreg;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_regwrite;
  logic                r_link;
  logic                r_addr_err;
  logic [DATA_W-1:0]   r_pc;
  logic [RETIRE_W-1:0] r_retire;

  load_align u_load_align (
    .is_load    (mem_is_load),
    .load_op    (mem_load_op),
    .addr_lo    (mem_addr_lo),
    .rdata      (mem_rdata),
    .load_data  (w_load_data),
    .misaligned (w_misaligned)
  );

  assign mem_ready    = !stall || flush;
  assign w_next_wdata = mem_is_load ? w_load_data : mem_alu_result;

  // Retirement counts the instruction leaving WB, so a flush of the incoming
  // slot still retires whatever currently sits in the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_wreg     <= 5'd0;
      r_wdata    <= '0;
      r_regwrite <= 1'b0;
      r_link     <= 1'b0;
      r_addr_err <= 1'b0;
      r_pc       <= '0;
      r_retire   <= '0;
    end else if (mem_ready) begin
      if (r_valid) begin
        r_retire <= r_retire + RETIRE_W'(1);
      end
      if (flush) begin
        r_valid    <= 1'b0;
        r_wreg     <= 5'd0;
        r_wdata    <= '0;
        r_regwrite <= 1'b0;
        r_link     <= 1'b0;
        r_addr_err <= 1'b0;
        r_pc       <= '0;
      end else begin
        r_valid    <= mem_valid;
        r_wreg     <= mem_wreg;
        r_wdata    <= w_next_wdata;
        r_regwrite <= mem_regwrite;
        r_link     <= mem_link;
        r_addr_err <= w_misaligned;
        r_pc       <= mem_pc;
      end
    end
  end

  // Link writes go to r31 via the PC path, never through the normal write port.
  assign wb_valid        = r_valid;
  assign wb_wreg         = r_wreg;
  assign wb_wdata        = r_wdata;
  assign wb_inst_address = r_pc;
  assign wb_addr_err     = r_valid & r_addr_err;
  assign wb_store_pc     = r_valid & r_link;
  assign wb_regwrite     = r_valid & r_regwrite & (r_wreg != 5'd0)
                           & !r_addr_err & !r_link;
  assign retire_count    = r_retire;

endmodule

`default_nettype wire
